// File: rtl/regfile_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter_if
// Description : Writeback requester handshakes and register-file write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wr_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_gnt;
    logic              m_req;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic              m_gnt;
    logic [ADDR_W-1:0] Awr;
    logic [DATA_W-1:0] Din;
    logic              WrEn;
    logic [3:0]        starve_cnt;

    // Requesters and register-file observer side
    modport master (
        output a_req, a_addr, a_data, m_req, m_addr, m_data,
        input  a_gnt, m_gnt, Awr, Din, WrEn, starve_cnt
    );

    // Arbiter side
    modport slave (
        input  a_req, a_addr, a_data, m_req, m_addr, m_data,
        output a_gnt, m_gnt, Awr, Din, WrEn, starve_cnt
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter
// Description : Two-requester arbiter for the single register-file write port,
//               load priority with anti-starvation for the ALU requester.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 3
) (
    input  wire logic           Clk,
    input  wire logic           reset,
    regfile_wr_arbiter_if.slave bus
);

    localparam logic [3:0] c_starve_max   = 4'(STARVE_MAX);
    localparam logic [3:0] c_starve_last  = 4'(STARVE_MAX - 1);

    typedef enum logic [0:0] {
        PRIO_M = 1'b0,
        PRIO_A = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_starve_cnt;
    logic [3:0]        w_starve_nxt;
    logic              w_a_gnt;
    logic              w_m_gnt;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_data;
    logic [ADDR_W-1:0] r_awr;
    logic [DATA_W-1:0] r_din;
    logic              r_wren;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state      <= PRIO_M;
            r_starve_cnt <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        w_a_gnt      = 1'b0;
        w_m_gnt      = 1'b0;
        case (r_state)
            PRIO_M: begin
                w_m_gnt = bus.m_req;
                w_a_gnt = bus.a_req & ~bus.m_req;
                if (bus.a_req && bus.m_req) begin
                    // A lost a contested cycle; the loss that reaches the limit hands priority to A
                    if (r_starve_cnt < c_starve_max) begin
                        w_starve_nxt = r_starve_cnt + 4'd1;
                    end
                    if (r_starve_cnt >= c_starve_last) begin
                        w_state_nxt = PRIO_A;
                    end
                end else if (bus.a_req) begin
                    w_starve_nxt = 4'd0;
                end
            end
            PRIO_A: begin
                w_a_gnt = bus.a_req;
                w_m_gnt = bus.m_req & ~bus.a_req;
                if (bus.a_req) begin
                    w_starve_nxt = 4'd0;
                    w_state_nxt  = PRIO_M;
                end
            end
            default: begin
                w_state_nxt = PRIO_M;
            end
        endcase
        if (reset) begin
            w_a_gnt = 1'b0;
            w_m_gnt = 1'b0;
        end
    end

    assign w_win_addr = w_m_gnt ? bus.m_addr : bus.a_addr;
    assign w_win_data = w_m_gnt ? bus.m_data : bus.a_data;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_awr  <= '0;
            r_din  <= '0;
            r_wren <= 1'b0;
        end else if (w_a_gnt || w_m_gnt) begin
            // Writes to register 0 are consumed but never enabled
            r_awr  <= w_win_addr;
            r_din  <= w_win_data;
            r_wren <= (w_win_addr != '0);
        end else begin
            r_wren <= 1'b0;
        end
    end

    assign bus.a_gnt      = w_a_gnt;
    assign bus.m_gnt      = w_m_gnt;
    assign bus.Awr        = r_awr;
    assign bus.Din        = r_din;
    assign bus.WrEn       = r_wren;
    assign bus.starve_cnt = r_starve_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wr_arbiter
// Description : Directed self-checking bench for regfile_wr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arbiter;

    logic Clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [31:0] rf [32];

    regfile_wr_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_wr_arbiter #(
        .DATA_W    (32),
        .ADDR_W    (5),
        .STARVE_MAX(3)
    ) u_dut (
        .Clk  (Clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Register_File stand-in, register 0 reads as zero
    always @(posedge Clk) begin
        if (bus.WrEn && bus.Awr != 5'd0) rf[bus.Awr] <= bus.Din;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        reset = 1'b1;
        bus.a_req = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'h66;
        bus.m_req = 1'b1; bus.m_addr = 5'd7; bus.m_data = 32'h55;

        // Reset with both requesting
        tick();
        chk("rst_a_gnt", 64'(bus.a_gnt), 64'd0);
        chk("rst_m_gnt", 64'(bus.m_gnt), 64'd0);
        chk("rst_wren",  64'(bus.WrEn), 64'd0);
        chk("rst_awr",   64'(bus.Awr), 64'd0);
        chk("rst_din",   64'(bus.Din), 64'd0);
        chk("rst_cnt",   64'(bus.starve_cnt), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_m_gnt", 64'(bus.m_gnt), 64'd1);
        chk("post_rst_a_gnt", 64'(bus.a_gnt), 64'd0);
        tick();
        bus.a_req = 1'b0; bus.m_req = 1'b0;
        chk("post_rst_din", 64'(bus.Din), 64'h55);
        chk("post_rst_awr", 64'(bus.Awr), 64'd7);
        chk("post_rst_cnt", 64'(bus.starve_cnt), 64'd1);
        do_reset();

        // A only
        bus.a_req = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'h3;
        #1;
        chk("aonly_a_gnt", 64'(bus.a_gnt), 64'd1);
        chk("aonly_m_gnt", 64'(bus.m_gnt), 64'd0);
        tick();
        bus.a_req = 1'b0;
        chk("aonly_wren", 64'(bus.WrEn), 64'd1);
        chk("aonly_awr",  64'(bus.Awr), 64'd5);
        chk("aonly_din",  64'(bus.Din), 64'd3);
        tick();
        chk("aonly_wren_off", 64'(bus.WrEn), 64'd0);
        chk("aonly_din_hold", 64'(bus.Din), 64'd3);
        do_reset();

        // Continuous contention
        bus.a_req = 1'b1; bus.a_addr = 5'd2; bus.a_data = 32'hA0;
        bus.m_req = 1'b1; bus.m_addr = 5'd1; bus.m_data = 32'h10;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("cont%0d_m_gnt", i), 64'(bus.m_gnt), 64'd1);
            chk($sformatf("cont%0d_a_gnt", i), 64'(bus.a_gnt), 64'd0);
            tick();
            chk($sformatf("cont%0d_cnt", i), 64'(bus.starve_cnt), 64'(i + 1));
            chk($sformatf("cont%0d_din", i), 64'(bus.Din), 64'(32'h10 + i));
            bus.m_data = 32'h11 + 32'(i);
        end
        #1;
        chk("cont_force_a_gnt", 64'(bus.a_gnt), 64'd1);
        chk("cont_force_m_gnt", 64'(bus.m_gnt), 64'd0);
        tick();
        bus.a_req = 1'b0;
        chk("cont_force_din", 64'(bus.Din), 64'hA0);
        chk("cont_force_awr", 64'(bus.Awr), 64'd2);
        chk("cont_force_cnt", 64'(bus.starve_cnt), 64'd0);
        #1;
        chk("cont_back_m_gnt", 64'(bus.m_gnt), 64'd1);
        tick();
        bus.m_req = 1'b0;
        chk("cont_back_din", 64'(bus.Din), 64'h13);
        chk("cont_back_cnt", 64'(bus.starve_cnt), 64'd0);

        // Address zero is granted but not written
        bus.m_req = 1'b1; bus.m_addr = 5'd0; bus.m_data = 32'hFFFF;
        #1;
        chk("zero_m_gnt", 64'(bus.m_gnt), 64'd1);
        tick();
        bus.m_req = 1'b0;
        chk("zero_wren", 64'(bus.WrEn), 64'd0);
        chk("zero_awr",  64'(bus.Awr), 64'd0);
        chk("zero_din",  64'(bus.Din), 64'hFFFF);
        tick();

        // Reset half a cycle after acceptance drops the pending write
        bus.a_req = 1'b1; bus.a_addr = 5'd16; bus.a_data = 32'h3;
        tick();
        bus.a_req = 1'b0;
        chk("midrst_wren_pre", 64'(bus.WrEn), 64'd1);
        #4;
        reset = 1'b1;
        #1;
        chk("midrst_wren", 64'(bus.WrEn), 64'd0);
        tick();
        chk("midrst_reg16", 64'(rf[16]), 64'd0);
        reset = 1'b0;

        // Same destination: M first, then A
        bus.a_req = 1'b1; bus.a_addr = 5'd16; bus.a_data = 32'd1;
        bus.m_req = 1'b1; bus.m_addr = 5'd16; bus.m_data = 32'd2;
        #1;
        chk("same_m_gnt", 64'(bus.m_gnt), 64'd1);
        tick();
        bus.m_req = 1'b0;
        chk("same_din_first", 64'(bus.Din), 64'd2);
        chk("same_wren_first", 64'(bus.WrEn), 64'd1);
        #1;
        chk("same_a_gnt", 64'(bus.a_gnt), 64'd1);
        tick();
        bus.a_req = 1'b0;
        chk("same_din_second", 64'(bus.Din), 64'd1);
        tick();
        chk("same_reg16", 64'(rf[16]), 64'd1);
        chk("reg0_zero", 64'(rf[0]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
